// File: rtl/fc_head_pkg.sv
// Shared types and Q4.12 helpers for the FC regression-head scheduler.
package fc_head_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_L1   = 3'd1,
        ST_W1   = 3'd2,
        ST_ACT  = 3'd3,
        ST_L2   = 3'd4,
        ST_W2   = 3'd5,
        ST_HOLD = 3'd6
    } sched_state_t;

    localparam int Q_WIDTH   = 16;
    localparam int FRAC_BITS = 12;

    // ReLU on a signed Q4.12 value: negatives clamp to zero.
    function automatic logic [Q_WIDTH-1:0] relu_q(input logic [Q_WIDTH-1:0] x);
        if (x[Q_WIDTH-1]) begin
            relu_q = {Q_WIDTH{1'b0}};
        end else begin
            relu_q = x;
        end
    endfunction

endpackage

// File: rtl/fc_head_scheduler_relu.sv
// fc_relu_buffer: HID-wide registered ReLU stage that loads on a one-cycle strobe.
module fc_relu_buffer
    import fc_head_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 100
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_load,
    input  logic [DATA_WIDTH*DEPTH-1:0] i_data,
    output logic [DATA_WIDTH*DEPTH-1:0] o_data
);

    localparam int W = DATA_WIDTH * DEPTH;

    logic [W-1:0] w_relu;
    logic [W-1:0] r_buf;

    for (genvar g = 0; g < DEPTH; g++) begin : g_relu
        logic [DATA_WIDTH-1:0] w_elem;
        assign w_elem = i_data[g*DATA_WIDTH +: DATA_WIDTH];
        if (DATA_WIDTH == Q_WIDTH) begin : g_q
            assign w_relu[g*DATA_WIDTH +: DATA_WIDTH] = relu_q(w_elem);
        end else begin : g_gen
            assign w_relu[g*DATA_WIDTH +: DATA_WIDTH] =
                w_elem[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : w_elem;
        end
    end

    // Hidden buffer register, written only while the scheduler is in ACT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf <= {W{1'b0}};
        end else if (i_load) begin
            r_buf <= w_relu;
        end else begin
            r_buf <= r_buf;
        end
    end

    assign o_data = r_buf;

endmodule

// File: rtl/fc_head_scheduler.sv
// Sequencer for the FC1 -> ReLU -> FC2 regression head with valid/ready on both ends.
// Optional build macro FC_SCHED_PERF_EN adds the perf_cycles latency output.
module fc_head_scheduler
    import fc_head_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int IN_DIM      = 200,
    parameter int HID_DIM     = 100,
    parameter int OUT_DIM     = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH*IN_DIM-1:0]  in_vector,
    output logic                          fc1_start,
    output logic [DATA_WIDTH*IN_DIM-1:0]  fc1_in_vector,
    input  logic [DATA_WIDTH*HID_DIM-1:0] fc1_out_vector,
    input  logic                          fc1_done,
    output logic                          fc2_start,
    output logic [DATA_WIDTH*HID_DIM-1:0] fc2_in_vector,
    input  logic [DATA_WIDTH*OUT_DIM-1:0] fc2_out_vector,
    input  logic                          fc2_done,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH*OUT_DIM-1:0] out_vector,
    output logic                          busy,
    output logic                          timeout_err
`ifdef FC_SCHED_PERF_EN
    ,
    output logic [31:0]                   perf_cycles
`endif
);

    localparam int IN_W  = DATA_WIDTH * IN_DIM;
    localparam int OUT_W = DATA_WIDTH * OUT_DIM;
    localparam logic        TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC) - 32'd1;

    sched_state_t      r_state;
    logic              r_in_ready;
    logic              r_fc1_start;
    logic              r_fc2_start;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_timeout_err;
    logic [IN_W-1:0]   r_fc1_in;
    logic [OUT_W-1:0]  r_out;
    logic [31:0]       r_wait_cnt;

    logic              w_relu_load;
    logic              w_wait_expired;

    assign w_relu_load    = (r_state == ST_ACT);
    // Expiry fires on the wait cycle that would bring the count to TIMEOUT_CYC.
    assign w_wait_expired = TO_EN && (r_wait_cnt == TO_LAST);

    fc_relu_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (HID_DIM)
    ) u_relu (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_relu_load),
        .i_data (fc1_out_vector),
        .o_data (fc2_in_vector)
    );

    // Scheduler FSM; every output flag is set on the transition into the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_in_ready    <= 1'b1;
            r_fc1_start   <= 1'b0;
            r_fc2_start   <= 1'b0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_fc1_in      <= {IN_W{1'b0}};
            r_out         <= {OUT_W{1'b0}};
            r_wait_cnt    <= 32'd0;
        end else begin
            r_fc1_start <= 1'b0;
            r_fc2_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_fc1_in    <= in_vector;
                        r_fc1_start <= 1'b1;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_L1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_L1: begin
                    r_wait_cnt <= 32'd0;
                    r_state    <= ST_W1;
                end
                ST_W1: begin
                    if (fc1_done) begin
                        r_state <= ST_ACT;
                    end else if (w_wait_expired) begin
                        r_timeout_err <= 1'b1;
                        r_in_ready    <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end
                ST_ACT: begin
                    r_fc2_start <= 1'b1;
                    r_state     <= ST_L2;
                end
                ST_L2: begin
                    r_wait_cnt <= 32'd0;
                    r_state    <= ST_W2;
                end
                ST_W2: begin
                    if (fc2_done) begin
                        r_out       <= fc2_out_vector;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else if (w_wait_expired) begin
                        r_timeout_err <= 1'b1;
                        r_in_ready    <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign fc1_start     = r_fc1_start;
    assign fc2_start     = r_fc2_start;
    assign fc1_in_vector = r_fc1_in;
    assign out_valid     = r_out_valid;
    assign out_vector    = r_out;
    assign busy          = r_busy;
    assign timeout_err   = r_timeout_err;

`ifdef FC_SCHED_PERF_EN
    logic [31:0] r_perf_cnt;
    logic [31:0] r_perf_cycles;

    // Running count starts at 1 on accept so the W2 exit load equals the accept-to-out_valid distance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cnt    <= 32'd0;
            r_perf_cycles <= 32'd0;
        end else begin
            if (r_state == ST_IDLE && in_valid) begin
                r_perf_cnt <= 32'd1;
            end else if (r_busy && r_perf_cnt != 32'hFFFF_FFFF) begin
                r_perf_cnt <= r_perf_cnt + 32'd1;
            end else begin
                r_perf_cnt <= r_perf_cnt;
            end
            if (r_state == ST_W2 && fc2_done) begin
                r_perf_cycles <= (r_perf_cnt == 32'hFFFF_FFFF) ? 32'hFFFF_FFFF
                                                               : r_perf_cnt + 32'd1;
            end else begin
                r_perf_cycles <= r_perf_cycles;
            end
        end
    end

    assign perf_cycles = r_perf_cycles;
`endif

endmodule
